// File: rtl/parity_unit.sv
// UART parity unit: TX parity generator and bit-serial RX parity checker
// with a saturating parity-error counter.
module parity_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clck,
  input  logic                  rst,
  input  logic                  par_en,
  input  logic [1:0]            par_mode,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  output logic                  par_bit,
  output logic                  par_valid,
  input  logic                  ser_start,
  input  logic                  ser_bit,
  input  logic                  ser_valid,
  output logic                  chk_done,
  output logic                  par_err,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  input  logic                  err_clr,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_e;

  // x is the XOR of all data bits; mode picks the parity rule
  function automatic logic par_of(input logic x, input logic [1:0] m);
    logic r;
    unique case (m)
      2'b00:   r = x;
      2'b01:   r = ~x;
      2'b10:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic                 par_bit_q, par_bit_d;
  logic                 par_valid_q, par_valid_d;
  logic                 tx_cap;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 acc_q, acc_d;
  logic [1:0]           mode_q, mode_d;
  logic                 chk_done_q, chk_done_d;
  logic                 par_err_q, par_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    tx_cap      = data_valid & par_en;
    par_valid_d = tx_cap;
    par_bit_d   = par_bit_q;
    if (tx_cap) begin
      par_bit_d = par_of(^p_data, par_mode);
    end
  end

  // Frame control: par_en loss aborts, ser_start restarts and wins
  // over a coincident ser_valid.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mode_d     = mode_q;
    chk_done_d = 1'b0;
    par_err_d  = 1'b0;
    if (!par_en) begin
      state_d = IDLE;
    end else if (ser_start) begin
      state_d = DATA;
      cnt_d   = '0;
      acc_d   = 1'b0;
      mode_d  = par_mode;
    end else if (ser_valid) begin
      unique case (state_q)
        DATA: begin
          acc_d = acc_q ^ ser_bit;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = PAR;
          end
        end
        PAR: begin
          chk_done_d = 1'b1;
          par_err_d  = ser_bit != par_of(acc_q, mode_q);
          state_d    = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (par_err_d && err_cnt_q != CNT_MAX) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clck) begin
    if (rst) begin
      par_bit_q   <= 1'b0;
      par_valid_q <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= 1'b0;
      mode_q      <= 2'b00;
      chk_done_q  <= 1'b0;
      par_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      par_bit_q   <= par_bit_d;
      par_valid_q <= par_valid_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      chk_done_q  <= chk_done_d;
      par_err_q   <= par_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign par_bit   = par_bit_q;
  assign par_valid = par_valid_q;
  assign chk_done  = chk_done_q;
  assign par_err   = par_err_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = state_q != IDLE;

endmodule

// File: tb/tb_parity_unit.sv
// Testbench for parity_unit: table-driven TX vectors, scoreboarded
// TX/RX results and hand-written RX frame corner cases.
module tb_parity_unit;

  logic       clck = 1'b0;
  logic       rst;
  logic       par_en;
  logic [1:0] par_mode;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_bit;
  logic       par_valid;
  logic       ser_start;
  logic       ser_bit;
  logic       ser_valid;
  logic       chk_done;
  logic       par_err;
  logic [1:0] err_cnt;
  logic       err_clr;
  logic       busy;

  parity_unit #(
    .DATA_WIDTH(8),
    .ERR_CNT_W (2)
  ) dut (
    .clck      (clck),
    .rst       (rst),
    .par_en    (par_en),
    .par_mode  (par_mode),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_bit   (par_bit),
    .par_valid (par_valid),
    .ser_start (ser_start),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .chk_done  (chk_done),
    .par_err   (par_err),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr),
    .busy      (busy)
  );

  always #5 clck = ~clck;

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] data;
    logic       exp;
  } tx_vec_t;

  tx_vec_t tv [12];

  int   n_checks = 0;
  int   n_errors = 0;
  logic tx_exp;
  logic exp_pb;
  logic [1:0] exp_cnt;
  logic tx_q [$];
  logic rx_q [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    logic cap;
    logic r;
    r   = rst;
    cap = data_valid & par_en & ~rst;
    if (cap) tx_q.push_back(tx_exp);
    if (r) begin
      tx_q.delete();
      rx_q.delete();
      exp_pb = 1'b0;
    end
    @(posedge clck);
    #1;
    chk("par_valid", 32'(par_valid), 32'(cap));
    if (par_valid) begin
      if (tx_q.size() == 0) begin
        chk("tx_queue_nonempty", 32'(0), 32'(1));
      end else begin
        exp_pb = tx_q.pop_front();
        chk("par_bit", 32'(par_bit), 32'(exp_pb));
      end
    end else begin
      chk("par_bit_hold", 32'(par_bit), 32'(exp_pb));
    end
    if (chk_done) begin
      if (rx_q.size() == 0) begin
        chk("unexpected_chk_done", 32'(1), 32'(0));
      end else begin
        chk("par_err", 32'(par_err), 32'(rx_q.pop_front()));
      end
    end else if (par_err) begin
      chk("par_err_without_chk_done", 32'(1), 32'(0));
    end
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic [1:0] m,
                          input logic pb, input logic exp_err,
                          input logic clr);
    par_mode  = m;
    ser_start = 1'b1;
    step();
    ser_start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(1));
    for (int i = 0; i < 8; i++) begin
      ser_valid = 1'b1;
      ser_bit   = d[i];
      step();
    end
    ser_bit = pb;
    err_clr = clr;
    rx_q.push_back(exp_err);
    step();
    ser_valid = 1'b0;
    err_clr   = 1'b0;
    if (clr) exp_cnt = 2'd0;
    else if (exp_err && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
    chk("chk_done_seen", 32'(rx_q.size()), 32'(0));
    chk("busy_after_par", 32'(busy), 32'(0));
    chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    tv[0]  = '{2'b00, 8'hA5, 1'b0};
    tv[1]  = '{2'b01, 8'h01, 1'b0};
    tv[2]  = '{2'b01, 8'h03, 1'b1};
    tv[3]  = '{2'b10, 8'h00, 1'b1};
    tv[4]  = '{2'b10, 8'h5A, 1'b1};
    tv[5]  = '{2'b11, 8'hFF, 1'b0};
    tv[6]  = '{2'b11, 8'h01, 1'b0};
    tv[7]  = '{2'b00, 8'h07, 1'b1};
    tv[8]  = '{2'b01, 8'h00, 1'b1};
    tv[9]  = '{2'b00, 8'h80, 1'b1};
    tv[10] = '{2'b01, 8'hFF, 1'b1};
    tv[11] = '{2'b00, 8'hC3, 1'b0};
    sat_exp[0] = 2'd1;
    sat_exp[1] = 2'd2;
    sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3;
    sat_exp[4] = 2'd3;

    rst = 1'b1; par_en = 1'b1; par_mode = 2'b00; p_data = 8'h00;
    data_valid = 1'b0; ser_start = 1'b0; ser_bit = 1'b0;
    ser_valid = 1'b0; err_clr = 1'b0; tx_exp = 1'b0;
    exp_pb = 1'b0; exp_cnt = 2'd0;
    step();
    step();
    rst = 1'b0;
    chk("rst_par_bit", 32'(par_bit), 32'(0));
    chk("rst_chk_done", 32'(chk_done), 32'(0));
    chk("rst_err_cnt", 32'(err_cnt), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));

    // single capture, then par_valid drops and par_bit holds
    par_mode = 2'b00; p_data = 8'hA5; tx_exp = 1'b0; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    step();
    step();

    // back-to-back captures over the vector table
    for (int i = 0; i < 12; i++) begin
      par_mode   = tv[i].mode;
      p_data     = tv[i].data;
      tx_exp     = tv[i].exp;
      data_valid = 1'b1;
      step();
    end
    data_valid = 1'b0;
    step();

    // capture ignored when parity disabled
    par_en = 1'b0; par_mode = 2'b10; tx_exp = 1'b1; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    par_en = 1'b1;
    step();

    // RX even: 8'h07 good then bad parity
    rx_frame(8'h07, 2'b00, 1'b1, 1'b0, 1'b0);
    rx_frame(8'h07, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("err_cnt_one", 32'(err_cnt), 32'(1));

    // saturation from zero
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    exp_cnt = 2'd0;
    chk("err_clr", 32'(err_cnt), 32'(0));
    for (int i = 0; i < 5; i++) begin
      rx_frame(8'h07, 2'b00, 1'b0, 1'b1, 1'b0);
      chk("err_cnt_sat", 32'(err_cnt), 32'(sat_exp[i]));
    end
    rx_frame(8'h07, 2'b00, 1'b0, 1'b1, 1'b1);
    chk("err_clr_coincident", 32'(err_cnt), 32'(0));

    // mark, space and odd modes, mode latched at frame start
    rx_frame(8'h00, 2'b10, 1'b0, 1'b1, 1'b0);
    rx_frame(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0);
    par_mode  = 2'b01;
    ser_start = 1'b1;
    step();
    ser_start = 1'b0;
    par_mode  = 2'b00;
    for (int i = 0; i < 8; i++) begin
      ser_valid = 1'b1;
      ser_bit   = (i < 3);
      step();
    end
    ser_bit = 1'b0;
    rx_q.push_back(1'b0);
    step();
    ser_valid = 1'b0;
    chk("mode_latched_done", 32'(rx_q.size()), 32'(0));

    // restart after 4 bits, then a full valid frame
    par_mode  = 2'b00;
    ser_start = 1'b1;
    step();
    ser_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ser_valid = 1'b1;
      ser_bit   = 1'b1;
      step();
    end
    ser_valid = 1'b0;
    rx_frame(8'h0F, 2'b00, 1'b0, 1'b0, 1'b0);

    // start and valid together: that bit is discarded
    ser_start = 1'b1; ser_valid = 1'b1; ser_bit = 1'b1;
    step();
    ser_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ser_bit = 1'b0;
      step();
    end
    ser_bit = 1'b0;
    rx_q.push_back(1'b0);
    step();
    ser_valid = 1'b0;
    chk("start_wins_done", 32'(rx_q.size()), 32'(0));

    // par_en dropping mid-frame aborts it
    ser_start = 1'b1;
    step();
    ser_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ser_valid = 1'b1; ser_bit = 1'b1;
      step();
    end
    ser_valid = 1'b0;
    par_en = 1'b0;
    step();
    chk("par_en_drop_busy", 32'(busy), 32'(0));
    par_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ser_valid = 1'b1; ser_bit = 1'b0;
      step();
    end
    ser_valid = 1'b0;

    // reset mid-frame with TX bit set and a nonzero counter
    rx_frame(8'h00, 2'b10, 1'b0, 1'b1, 1'b0);
    par_mode = 2'b10; tx_exp = 1'b1; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    ser_start = 1'b1;
    step();
    ser_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ser_valid = 1'b1; ser_bit = 1'b1;
      step();
    end
    chk("busy_before_rst", 32'(busy), 32'(1));
    rst = 1'b1; data_valid = 1'b1;
    step();
    rst = 1'b0; data_valid = 1'b0; ser_valid = 1'b0;
    exp_cnt = 2'd0;
    chk("rst_mid_busy", 32'(busy), 32'(0));
    chk("rst_mid_par_bit", 32'(par_bit), 32'(0));
    chk("rst_mid_err_cnt", 32'(err_cnt), 32'(0));
    chk("rst_mid_chk_done", 32'(chk_done), 32'(0));
    for (int i = 0; i < 9; i++) begin
      ser_valid = 1'b1; ser_bit = 1'b1;
      step();
    end
    ser_valid = 1'b0;
    step();
    chk("rx_queue_empty_end", 32'(rx_q.size()), 32'(0));
    chk("tx_queue_empty_end", 32'(tx_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
